ro_sensor_hub: RTL and testbench

Multi-channel successor to the single ring-oscillator counter, duty-cycle circuit and UART sender chain. It does four things for N ring-oscillator inputs:
- measures rising-edge count (frequency proxy) and high-time (duty) over a shared power-of-two gate window;
- double-buffers the results;
- streams them as checksummed 6-byte frames on one UART line;
- exposes a selectable channel count byte for the seven-segment display controller.

---
 rtl/ro_sensor_hub.sv | 224 ++++++++++++++++++++++
 tb/tb_ro_sensor_hub.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_sensor_hub.sv
// ro_sensor_hub: N-channel ring-oscillator edge/duty meter with
// double-buffered snapshots, 6-byte UART frames and a display byte.
module ro_sensor_hub #(
  parameter int N_CH      = 2,
  parameter int COUNT_W   = 16,
  parameter int GATE_LOG2 = 10,
  parameter int CLK_HZ    = 100000000,
  parameter int BAUD      = 9600
) (
  input  logic            fpga_clk1,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_CH-1:0] ring_in,
  input  logic [3:0]      disp_sel,
  output logic [7:0]      disp_value,
  output logic            tx,
  output logic            busy,
  output logic            overrun
);

  localparam int BIT_CYCLES = CLK_HZ / BAUD;
  localparam int BC_W = $clog2(BIT_CYCLES + 1);
  localparam int HI_W = GATE_LOG2 + 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [GATE_LOG2-1:0] GATE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;

  logic [N_CH-1:0] s1_q, s2_q, s3_q;
  logic [N_CH-1:0] rise_w, high_w;

  logic [GATE_LOG2-1:0] gate_q, gate_d;
  logic [COUNT_W-1:0] edge_q [N_CH];
  logic [COUNT_W-1:0] edge_d [N_CH];
  logic [COUNT_W-1:0] edge_nx [N_CH];
  logic [HI_W-1:0] high_q [N_CH];
  logic [HI_W-1:0] high_d [N_CH];
  logic [HI_W-1:0] high_nx [N_CH];
  logic [HI_W-1:0] duty_sh [N_CH];
  logic [COUNT_W-1:0] snap_cnt_q [N_CH];
  logic [COUNT_W-1:0] snap_cnt_d [N_CH];
  logic [7:0] snap_duty_q [N_CH];
  logic [7:0] snap_duty_d [N_CH];
  logic overrun_q, overrun_d;
  logic term, take;

  state_t state_q, state_d;
  logic [BC_W-1:0] cyc_q, cyc_d;
  logic [2:0] bit_q, bit_d;
  logic [2:0] byte_q, byte_d;
  logic [3:0] ch_q, ch_d;
  logic [7:0] sh_q, sh_d;
  logic tx_q, tx_d;
  logic last_cyc;
  logic [15:0] sel_cnt;
  logic [7:0] sel_duty, chk, byte_val;

  // Synchroniser chain; it carries no state worth clearing on reset.
  always_ff @(posedge fpga_clk1) begin
    s1_q <= ring_in;
    s2_q <= s1_q;
    s3_q <= s2_q;
  end

  assign rise_w = s2_q & ~s3_q;
  assign high_w = s2_q;

  // Gate window, per-channel accumulation and snapshot capture.
  always_comb begin
    term = enable && (gate_q == GATE_MAX);
    take = term && !busy;
    gate_d = enable ? gate_q + 1'b1 : '0;
    overrun_d = overrun_q | (term & busy);
    for (int c = 0; c < N_CH; c++) begin
      edge_nx[c] = edge_q[c];
      if (rise_w[c] && (edge_q[c] != CNT_MAX))
        edge_nx[c] = edge_q[c] + 1'b1;
      high_nx[c] = high_q[c] + HI_W'(high_w[c]);
      edge_d[c] = (enable && !term) ? edge_nx[c] : '0;
      high_d[c] = (enable && !term) ? high_nx[c] : '0;
      duty_sh[c] = high_nx[c] >> (GATE_LOG2 - 8);
      snap_cnt_d[c] = snap_cnt_q[c];
      snap_duty_d[c] = snap_duty_q[c];
      if (take) begin
        snap_cnt_d[c] = edge_nx[c];
        snap_duty_d[c] = (duty_sh[c] > HI_W'(255)) ?
                         8'hFF : duty_sh[c][7:0];
      end
    end
  end

  // Measurement registers.
  always_ff @(posedge fpga_clk1) begin
    if (reset) begin
      gate_q <= '0;
      overrun_q <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        edge_q[c] <= '0;
        high_q[c] <= '0;
        snap_cnt_q[c] <= '0;
        snap_duty_q[c] <= '0;
      end
    end else begin
      gate_q <= gate_d;
      overrun_q <= overrun_d;
      for (int c = 0; c < N_CH; c++) begin
        edge_q[c] <= edge_d[c];
        high_q[c] <= high_d[c];
        snap_cnt_q[c] <= snap_cnt_d[c];
        snap_duty_q[c] <= snap_duty_d[c];
      end
    end
  end

  // Display mux and frame byte selection from the snapshot.
  always_comb begin
    sel_cnt = '0;
    sel_duty = '0;
    disp_value = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_q == 4'(c)) begin
        sel_cnt = 16'(snap_cnt_q[c]);
        sel_duty = snap_duty_q[c];
      end
      if (disp_sel == 4'(c))
        disp_value = 8'(snap_cnt_q[c]);
    end
    chk = 8'hA5 ^ {4'h0, ch_q} ^ sel_cnt[15:8]
        ^ sel_cnt[7:0] ^ sel_duty;
    unique case (byte_q)
      3'd0: byte_val = 8'hA5;
      3'd1: byte_val = {4'h0, ch_q};
      3'd2: byte_val = sel_cnt[15:8];
      3'd3: byte_val = sel_cnt[7:0];
      3'd4: byte_val = sel_duty;
      default: byte_val = chk;
    endcase
  end

  // Transmit FSM; LOAD doubles as the first clock of the start bit.
  always_comb begin
    state_d = state_q;
    cyc_d = cyc_q + 1'b1;
    bit_d = bit_q;
    byte_d = byte_q;
    ch_d = ch_q;
    sh_d = sh_q;
    last_cyc = (cyc_q == BC_W'(BIT_CYCLES - 1));
    unique case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (take) begin
          state_d = S_LOAD;
          byte_d = '0;
          ch_d = '0;
        end
      end
      S_LOAD: begin
        sh_d = byte_val;
        state_d = S_START;
      end
      S_START: begin
        if (last_cyc) begin
          state_d = S_DATA;
          cyc_d = '0;
          bit_d = '0;
        end
      end
      S_DATA: begin
        if (last_cyc) begin
          cyc_d = '0;
          sh_d = sh_q >> 1;
          if (bit_q == 3'd7) state_d = S_STOP;
          else bit_d = bit_q + 1'b1;
        end
      end
      S_STOP: begin
        if (last_cyc) begin
          cyc_d = '0;
          state_d = S_LOAD;
          if (byte_q == 3'd5) begin
            byte_d = '0;
            if (ch_q == 4'(N_CH - 1)) state_d = S_IDLE;
            else ch_d = ch_q + 1'b1;
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    tx_d = 1'b1;
    if (state_d == S_LOAD || state_d == S_START) tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = sh_d[0];
  end

  // Transmit state register; tx is registered so the line never glitches.
  always_ff @(posedge fpga_clk1) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      ch_q <= '0;
      sh_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      ch_q <= ch_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign tx = tx_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_ro_sensor_hub.sv
// tb_ro_sensor_hub: table rows plus random ring stimulus checked
// against a window-level model of counts, duty and frame timing.
module tb_ro_sensor_hub;
  localparam int N = 2;
  localparam int CW = 8;
  localparam int GL = 10;
  localparam int BC = 10;
  localparam int WIN = 1 << GL;
  localparam int FRAME = N * 60 * BC;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, enable;
  logic [N-1:0] ring_in = '0;
  logic [3:0] disp_sel;
  logic [7:0] disp_value;
  logic tx, busy, overrun;

  ro_sensor_hub #(
    .N_CH(N), .COUNT_W(CW), .GATE_LOG2(GL),
    .CLK_HZ(1000000), .BAUD(100000)
  ) dut (
    .fpga_clk1(clk), .reset(reset), .enable(enable),
    .ring_in(ring_in), .disp_sel(disp_sel),
    .disp_value(disp_value), .tx(tx), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] fbyte(int ch, int cnt,
                                       int duty, int idx);
    logic [7:0] b [6];
    b[0] = 8'hA5;
    b[1] = 8'(ch);
    b[2] = 8'(cnt >> 8);
    b[3] = 8'(cnt);
    b[4] = 8'(duty);
    b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
    return b[idx];
  endfunction

  // ring stimulus: 0 low, 1 high, 2 square wave, 3 random toggling
  int mode [N];
  int per [N];
  int gtick = 0;
  initial forever begin
    @(negedge clk);
    gtick++;
    for (int c = 0; c < N; c++) begin
      case (mode[c])
        0: ring_in[c] = 1'b0;
        1: ring_in[c] = 1'b1;
        2: ring_in[c] = (gtick % per[c]) < (per[c] / 2);
        default:
          if ($urandom_range(0, 3) == 0) ring_in[c] = ~ring_in[c];
      endcase
    end
  end

  // window-level reference model
  logic [N-1:0] hist [$];
  int cur_p = 0;
  int m_phase = 0;
  int m_busy_until = 0;
  int m_ovr = 0;
  int m_n_acc = 0;
  int m_last_acc = 0;
  int m_cnt [N];
  int m_duty [N];
  logic [7:0] ex_b [$];
  int ex_t [$];

  always @(posedge clk) begin
    int p, e, h;
    hist.push_back(ring_in);
    p = hist.size() - 1;
    cur_p = p;
    if (reset) begin
      m_phase = 0;
      m_busy_until = p;
      m_ovr = 0;
      for (int c = 0; c < N; c++) begin
        m_cnt[c] = 0;
        m_duty[c] = 0;
      end
    end else if (enable) begin
      if (m_phase == WIN - 1) begin
        m_phase = 0;
        if (p > m_busy_until) begin
          for (int c = 0; c < N; c++) begin
            e = 0;
            h = 0;
            for (int k = p - WIN + 1; k <= p; k++) begin
              if (hist[k-2][c] && !hist[k-3][c]) e++;
              if (hist[k-2][c]) h++;
            end
            m_cnt[c] = (e > CMAX) ? CMAX : e;
            m_duty[c] = ((h >> (GL - 8)) > 255) ? 255 : (h >> (GL - 8));
            for (int b = 0; b < 6; b++) begin
              ex_b.push_back(fbyte(c, m_cnt[c], m_duty[c], b));
              ex_t.push_back(p + (c * 6 + b) * 10 * BC);
            end
          end
          m_busy_until = p + FRAME;
          m_last_acc = p;
          m_n_acc++;
        end else begin
          m_ovr = 1;
        end
      end else begin
        m_phase++;
      end
    end else begin
      m_phase = 0;
    end
  end

  // UART receiver sampling bit centres
  logic [7:0] rx_b [$];
  int rx_t [$];
  int stop_bad = 0;
  initial forever begin
    int t0;
    logic [7:0] b;
    @(negedge clk);
    if (tx === 1'b0) begin
      t0 = cur_p;
      b = '0;
      tick(BC / 2);
      for (int i = 0; i < 8; i++) begin
        tick(BC);
        b[i] = tx;
      end
      tick(BC);
      if (tx !== 1'b1) stop_bad++;
      rx_b.push_back(b);
      rx_t.push_back(t0);
    end
  end

  task automatic flush();
    rx_b.delete();
    rx_t.delete();
    ex_b.delete();
    ex_t.delete();
    stop_bad = 0;
  endtask

  task automatic compare_frames(string tag);
    int n;
    chk({tag, " nbytes"}, rx_b.size(), ex_b.size());
    chk({tag, " stopbit"}, stop_bad, 0);
    n = (rx_b.size() < ex_b.size()) ? rx_b.size() : ex_b.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s byte%0d", tag, i), rx_b[i], ex_b[i]);
      chk($sformatf("%s time%0d", tag, i), rx_t[i], ex_t[i]);
    end
    flush();
  endtask

  typedef struct {
    int m0, p0, m1, p1, sel;
    int c0, d0, c1, d1, dv;
  } row_t;
  row_t rows [4];

  initial begin
    int e0, n0, t, guard, b;
    rows[0] = '{2, 8, 2, 16, 1, 'h80, 'h80, 'h40, 'h80, 'h40};
    rows[1] = '{2, 4, 1, 0, 0, 'hFF, 'h80, 0, 'hFF, 'hFF};
    rows[2] = '{0, 0, 2, 2, 5, 0, 0, 'hFF, 'h80, 0};
    rows[3] = '{1, 0, 0, 0, 0, 0, 'hFF, 0, 0, 0};
    for (int c = 0; c < N; c++) begin
      mode[c] = 0;
      per[c] = 8;
    end
    reset = 1'b1;
    enable = 1'b0;
    disp_sel = '0;
    tick(6);
    reset = 1'b0;
    tick(1);
    chk("reset tx", tx, 1);
    chk("reset busy", busy, 0);
    chk("reset overrun", overrun, 0);
    chk("reset disp", disp_value, 0);

    for (int r = 0; r < 4; r++) begin
      enable = 1'b0;
      mode[0] = rows[r].m0;
      per[0] = rows[r].p0;
      mode[1] = rows[r].m1;
      per[1] = rows[r].p1;
      disp_sel = 4'(rows[r].sel);
      tick(3000);
      chk($sformatf("row%0d disabled bytes", r), rx_b.size(), 0);
      chk($sformatf("row%0d disabled busy", r), busy, 0);
      flush();
      enable = 1'b1;
      e0 = cur_p;
      tick(1023);
      chk($sformatf("row%0d busy pre", r), busy, 0);
      tick(1);
      chk($sformatf("row%0d busy post", r), busy, 1);
      chk($sformatf("row%0d disp", r), disp_value, rows[r].dv);
      if (r == 0) chk("row0 overrun first", overrun, 0);
      tick(FRAME + 30);
      enable = 1'b0;
      chk($sformatf("row%0d overrun", r), overrun, 1);
      chk($sformatf("row%0d nbytes", r), rx_b.size(), 12);
      if (rx_b.size() >= 12) begin
        chk($sformatf("row%0d start", r), rx_t[0], e0 + WIN);
        for (int i = 0; i < 12; i++) begin
          b = (i < 6) ? fbyte(0, rows[r].c0, rows[r].d0, i)
                      : fbyte(1, rows[r].c1, rows[r].d1, i - 6);
          chk($sformatf("row%0d byte%0d", r, i), rx_b[i], b);
        end
      end
      flush();
    end

    for (int rnd = 0; rnd < 2; rnd++) begin
      mode[0] = 3;
      mode[1] = 3;
      tick(20);
      flush();
      enable = 1'b1;
      tick(4300);
      enable = 1'b0;
      tick(100);
      compare_frames($sformatf("rand%0d", rnd));
      chk("rand overrun", overrun, m_ovr);
      for (int s = 0; s < 4; s++) begin
        disp_sel = 4'(s);
        tick(1);
        chk($sformatf("rand disp%0d", s), disp_value,
            (s < N) ? (m_cnt[s] & 255) : 0);
      end
    end

    enable = 1'b1;
    n0 = m_n_acc;
    guard = 0;
    while (m_n_acc == n0 && guard < 3 * WIN) begin
      tick(1);
      guard++;
    end
    chk("reset test snapshot seen", (m_n_acc != n0) ? 1 : 0, 1);
    t = m_last_acc + 4 * BC + 3;
    guard = 0;
    while (cur_p < t && guard < 3 * WIN) begin
      tick(1);
      guard++;
    end
    chk("mid-byte busy", busy, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid-reset tx", tx, 1);
    chk("mid-reset busy", busy, 0);
    chk("mid-reset overrun", overrun, 0);
    chk("mid-reset disp", disp_value, 0);
    tick(200);
    flush();
    tick(2400);
    enable = 1'b0;
    tick(50);
    compare_frames("post-reset");
    chk("post-reset overrun", overrun, m_ovr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
